dm_cache_ctrl: RTL and testbench

- Controller for the direct-mapped, write-back, write-allocate 16 KB data cache.
- Sequences the external 1024 x 128-bit line data array through its index, write-enable, write-data and combinational read-data ports.
- Holds the tag/valid/dirty store internally.
- Serves a single 32-bit CPU word port and fetches or evicts whole 128-bit lines over a valid/ready memory port.

---
 rtl/dm_cache_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with internal tag/valid/dirty store.
// Optional hit/miss/write-back counters are built when CACHE_STATS_EN is defined.
module dm_cache_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INDEX_W = 10,
    parameter int unsigned TAG_W   = 18,
    parameter int unsigned LINE_W  = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic               cpu_req_rw,
    input  logic [ADDR_W-1:0]  cpu_req_addr,
    input  logic [31:0]        cpu_req_data,
    output logic               cpu_res_valid,
    output logic [31:0]        cpu_res_data,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_rw,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic [LINE_W-1:0]  mem_req_data,
    input  logic               mem_res_valid,
    input  logic [LINE_W-1:0]  mem_res_data,
    output logic [INDEX_W-1:0] data_req_index,
    output logic               data_req_we,
    output logic [LINE_W-1:0]  data_write,
    input  logic [LINE_W-1:0]  data_read,
    output logic [31:0]        stat_hit,
    output logic [31:0]        stat_miss,
    output logic [31:0]        stat_wb
);
    localparam int unsigned Lines = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteBack,
        StAllocReq,
        StAllocWait
    } state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] req_index_q;
    logic [1:0]         req_word_q;
    logic               req_rw_q;
    logic [31:0]        req_data_q;

    // Tags are not reset; valid_q alone decides whether a tag is meaningful.
    logic [TAG_W-1:0] tag_q [Lines];
    logic [Lines-1:0] valid_q;
    logic [Lines-1:0] dirty_q;

    logic [TAG_W-1:0] cur_tag;
    logic             hit;
    logic             accept;
    logic             refill;
    logic             write_hit;
    logic             unused_addr_bits;

    assign cur_tag          = tag_q[req_index_q];
    assign hit              = valid_q[req_index_q] && (cur_tag == req_tag_q);
    assign accept           = (state_q == StIdle) && cpu_req_valid;
    assign refill           = (state_q == StAllocWait) && mem_res_valid;
    assign write_hit        = (state_q == StCompare) && hit && req_rw_q;
    assign data_req_index   = req_index_q;
    assign unused_addr_bits = ^cpu_req_addr[1:0];

    always_comb begin
        state_d       = state_q;
        cpu_req_ready = 1'b0;
        cpu_res_valid = 1'b0;
        cpu_res_data  = '0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        data_req_we   = 1'b0;
        data_write    = '0;
        unique case (state_q)
            StIdle: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_d = StCompare;
            end
            StCompare: begin
                if (hit) begin
                    cpu_res_valid = 1'b1;
                    state_d       = StIdle;
                    if (req_rw_q) begin
                        data_req_we = 1'b1;
                        data_write  = data_read;
                        data_write[{req_word_q, 5'd0} +: 32] = req_data_q;
                    end else begin
                        cpu_res_data = data_read[{req_word_q, 5'd0} +: 32];
                    end
                end else if (valid_q[req_index_q] && dirty_q[req_index_q]) begin
                    state_d = StWriteBack;
                end else begin
                    state_d = StAllocReq;
                end
            end
            StWriteBack: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {cur_tag, req_index_q, 4'b0000};
                mem_req_data  = data_read;
                if (mem_req_ready) state_d = StAllocReq;
            end
            StAllocReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag_q, req_index_q, 4'b0000};
                if (mem_req_ready) state_d = StAllocWait;
            end
            StAllocWait: begin
                if (mem_res_valid) begin
                    data_req_we = 1'b1;
                    data_write  = mem_res_data;
                    state_d     = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_word_q  <= '0;
            req_rw_q    <= 1'b0;
            req_data_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_tag_q   <= cpu_req_addr[ADDR_W-1 -: TAG_W];
                req_index_q <= cpu_req_addr[INDEX_W+3:4];
                req_word_q  <= cpu_req_addr[3:2];
                req_rw_q    <= cpu_req_rw;
                req_data_q  <= cpu_req_data;
            end
            if (refill) begin
                valid_q[req_index_q] <= 1'b1;
                dirty_q[req_index_q] <= 1'b0;
            end
            if (write_hit) dirty_q[req_index_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && refill) tag_q[req_index_q] <= req_tag_q;
    end

`ifdef CACHE_STATS_EN
    // first_cmp_q separates the lookup of a new request from the post-refill lookup.
    logic        first_cmp_q;
    logic [31:0] stat_hit_q;
    logic [31:0] stat_miss_q;
    logic [31:0] stat_wb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_cmp_q <= 1'b0;
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
            stat_wb_q   <= '0;
        end else begin
            if (accept) begin
                first_cmp_q <= 1'b1;
            end else if (state_q == StCompare) begin
                first_cmp_q <= 1'b0;
            end
            if ((state_q == StCompare) && first_cmp_q) begin
                if (hit) stat_hit_q <= stat_hit_q + 32'd1;
                else     stat_miss_q <= stat_miss_q + 32'd1;
            end
            if ((state_q == StWriteBack) && mem_req_ready) stat_wb_q <= stat_wb_q + 32'd1;
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
    assign stat_wb   = stat_wb_q;
`else
    assign stat_hit  = '0;
    assign stat_miss = '0;
    assign stat_wb   = '0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed vector table, reset corner cases, then random traffic
// checked against a flat-memory reference model of the cache.
module tb_dm_cache_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_ready;
    logic         cpu_req_rw = 1'b0;
    logic [31:0]  cpu_req_addr = '0;
    logic [31:0]  cpu_req_data = '0;
    logic         cpu_res_valid;
    logic [31:0]  cpu_res_data;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_res_valid = 1'b0;
    logic [127:0] mem_res_data = '0;
    logic [9:0]   data_req_index;
    logic         data_req_we;
    logic [127:0] data_write;
    logic [127:0] data_read;
    logic [31:0]  stat_hit, stat_miss, stat_wb;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_data   (cpu_req_data),
        .cpu_res_valid  (cpu_res_valid),
        .cpu_res_data   (cpu_res_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_res_valid  (mem_res_valid),
        .mem_res_data   (mem_res_data),
        .data_req_index (data_req_index),
        .data_req_we    (data_req_we),
        .data_write     (data_write),
        .data_read      (data_read),
        .stat_hit       (stat_hit),
        .stat_miss      (stat_miss),
        .stat_wb        (stat_wb)
    );

    // External line data array: combinational read, synchronous write.
    logic [127:0] darr [1024];
    assign data_read = darr[data_req_index];
    always @(posedge clk) if (data_req_we) darr[data_req_index] <= data_write;

    int total = 0;
    int bad = 0;
    bit junk_en = 1'b0;

    logic [127:0] mem [logic [31:0]];     // backing memory, survives reset
    logic [31:0]  ref_wr [logic [31:0]];  // CPU writes not yet visible in backing memory
    bit           m_valid [1024];
    bit           m_dirty [1024];
    logic [17:0]  m_tag [1024];
    int unsigned  m_hit, m_miss, m_wb;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [31:0] a);
        return {a ^ 32'h3333_0000, a ^ 32'h2222_0000, a ^ 32'h1111_0000, a};
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        if (mem.exists(la)) return mem[la];
        return init_line(la);
    endfunction

    function automatic logic [31:0] arch_word(input logic [31:0] a);
        logic [31:0]  wa;
        logic [127:0] ln;
        wa = {a[31:2], 2'b00};
        if (ref_wr.exists(wa)) return ref_wr[wa];
        ln = mem_line({a[31:4], 4'h0});
        return ln[{a[3:2], 5'd0} +: 32];
    endfunction

    function automatic logic [127:0] arch_line(input logic [31:0] la);
        return {arch_word(la + 32'd12), arch_word(la + 32'd8), arch_word(la + 32'd4), arch_word(la)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        ref_wr.delete();
        m_hit  = 0;
        m_miss = 0;
        m_wb   = 0;
    endfunction

    // Predicts one request from the cache rules; latency counts cycles from accept to response.
    function automatic void model_step(input logic rw, input logic [31:0] addr,
        input logic [31:0] wd, input int d, input int r, output logic [31:0] e_rd,
        output int e_lat, output bit e_wb, output logic [31:0] e_wba,
        output logic [127:0] e_wbd, output bit e_f, output logic [31:0] e_fa);
        logic [9:0]  idx;
        logic [17:0] tg;
        idx   = addr[13:4];
        tg    = addr[31:14];
        e_wb  = 1'b0;
        e_f   = 1'b0;
        e_wba = '0;
        e_wbd = '0;
        e_fa  = '0;
        e_rd  = rw ? 32'h0 : arch_word(addr);
        if (m_valid[idx] && m_tag[idx] == tg) begin
            m_hit++;
            e_lat = 1;
        end else begin
            m_miss++;
            e_f   = 1'b1;
            e_fa  = {addr[31:4], 4'h0};
            e_lat = 4 + d + r;
            if (m_valid[idx] && m_dirty[idx]) begin
                e_wb  = 1'b1;
                e_wba = {m_tag[idx], idx, 4'h0};
                e_wbd = arch_line(e_wba);
                e_lat = e_lat + 1 + d;
                m_wb++;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (rw) begin
            m_dirty[idx] = 1'b1;
            ref_wr[{addr[31:2], 2'b00}] = wd;
        end
    endfunction

    task automatic chk_stats(input string nm);
`ifdef CACHE_STATS_EN
        chk({nm, "_stat_hit"}, stat_hit, m_hit);
        chk({nm, "_stat_miss"}, stat_miss, m_miss);
        chk({nm, "_stat_wb"}, stat_wb, m_wb);
`else
        chk({nm, "_stat_zero"}, {stat_hit, stat_miss, stat_wb}, 96'h0);
`endif
    endtask

    // Issues one request and plays the memory side; dly stalls each mem request, rdly delays refill.
    task automatic run_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
        input int dly, input int rdly, input bit poke, output logic [31:0] rdata,
        output int lat, output int n_wb, output logic [31:0] wb_addr,
        output logic [127:0] wb_data, output int n_f, output logic [31:0] f_addr);
        int           hold;
        int           rwait;
        bit           fetch_pend;
        bit           done;
        logic         first_rw;
        logic [31:0]  first_addr;
        logic [127:0] first_data;
        hold = 0; rwait = 0; fetch_pend = 0; done = 0; lat = 0;
        n_wb = 0; n_f = 0; rdata = '0; wb_addr = '0; wb_data = '0; f_addr = '0;
        first_rw = 1'b0; first_addr = '0; first_data = '0;
        @(negedge clk);
        chk("idle_ready", cpu_req_ready, 1'b1);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_data  = wd;
        mem_req_ready = 1'b0;
        mem_res_valid = 1'b0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            cpu_req_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (poke) cpu_req_addr = $urandom;
            mem_res_valid = 1'b0;
            chk("busy_ready", cpu_req_ready, 1'b0);
            chk("data_index", data_req_index, addr[13:4]);
            if (cpu_res_valid) begin
                done = 1'b1;
                rdata = cpu_res_data;
                cpu_req_valid = 1'b0;
            end
            if (mem_req_valid) begin
                if (hold == 0) begin
                    first_rw = mem_req_rw;
                    first_addr = mem_req_addr;
                    first_data = mem_req_data;
                end else begin
                    chk("stall_rw", mem_req_rw, first_rw);
                    chk("stall_addr", mem_req_addr, first_addr);
                    chk("stall_data", mem_req_data, first_data);
                end
                if (hold < dly) begin
                    hold++;
                    mem_req_ready = 1'b0;
                end else begin
                    hold = 0;
                    mem_req_ready = 1'b1;
                    if (mem_req_rw) begin
                        n_wb++;
                        wb_addr = mem_req_addr;
                        wb_data = mem_req_data;
                        mem[mem_req_addr] = mem_req_data;
                    end else begin
                        n_f++;
                        f_addr = mem_req_addr;
                        fetch_pend = 1'b1;
                        rwait = 0;
                    end
                end
            end else begin
                mem_req_ready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
                if (fetch_pend) begin
                    if (rwait < rdly) begin
                        rwait++;
                    end else begin
                        mem_res_valid = 1'b1;
                        mem_res_data = mem_line(f_addr);
                        fetch_pend = 1'b0;
                    end
                end else if (junk_en && !done) begin
                    mem_res_valid = 1'($urandom_range(0, 1));
                    mem_res_data = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        cpu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        if (!done) chk("response_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_checked(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
        input int d, input int r, input bit poke, input string nm);
        logic [31:0]  e_rd, a_rd, e_wba, a_wba, e_fa, a_fa;
        logic [127:0] e_wbd, a_wbd;
        int           e_lat, a_lat, a_nwb, a_nf;
        bit           e_wb, e_f;
        model_step(rw, addr, wd, d, r, e_rd, e_lat, e_wb, e_wba, e_wbd, e_f, e_fa);
        run_req(rw, addr, wd, d, r, poke, a_rd, a_lat, a_nwb, a_wba, a_wbd, a_nf, a_fa);
        if (!rw) chk({nm, "_rdata"}, a_rd, e_rd);
        chk({nm, "_lat"}, a_lat, e_lat);
        chk({nm, "_wb_cnt"}, a_nwb, e_wb);
        if (e_wb) begin
            chk({nm, "_wb_addr"}, a_wba, e_wba);
            chk({nm, "_wb_data"}, a_wbd, e_wbd);
        end
        chk({nm, "_fetch_cnt"}, a_nf, e_f);
        if (e_f) chk({nm, "_fetch_addr"}, a_fa, e_fa);
        chk_stats(nm);
    endtask

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        int           d;
        int           r;
        bit           poke;
        logic [31:0]  rdata;
        int           lat;
        bit           wb;
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        bit           fetch;
        logic [31:0]  f_addr;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [31:0]  a_rd, a_wba, a_fa, e_rd, e_wba, e_fa;
        logic [127:0] a_wbd, e_wbd;
        int           a_lat, a_nwb, a_nf, e_lat;
        bit           e_wb, e_f;
        string        nm;

        vt[0]  = '{1'b0, 32'h10,   32'h0, 0, 0, 1'b0, 32'h2, 4, 1'b0, 32'h0, 128'h0, 1'b1, 32'h10};
        vt[1]  = '{1'b0, 32'h10,   32'h0, 0, 0, 1'b0, 32'h2, 1, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0};
        vt[2]  = '{1'b1, 32'h1C, 32'hCAFE_BABE, 0, 0, 1'b0, 32'h0, 1, 1'b0, 32'h0, 128'h0,
                   1'b0, 32'h0};
        vt[3]  = '{1'b0, 32'h1C,   32'h0, 0, 0, 1'b0, 32'hCAFE_BABE, 1, 1'b0, 32'h0, 128'h0,
                   1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h14,   32'h0, 0, 0, 1'b0, 32'h3, 1, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 32'h18,   32'h0, 0, 0, 1'b0, 32'h4, 1, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 32'h4010, 32'h0, 5, 2, 1'b1, 32'h4010, 17, 1'b1, 32'h10,
                   128'hCAFE_BABE_0000_0004_0000_0003_0000_0002, 1'b1, 32'h4010};
        vt[7]  = '{1'b0, 32'h1C,   32'h0, 1, 1, 1'b0, 32'hCAFE_BABE, 6, 1'b0, 32'h0, 128'h0,
                   1'b1, 32'h10};
        vt[8]  = '{1'b1, 32'h3FF0, 32'h1234_5678, 0, 3, 1'b0, 32'h0, 7, 1'b0, 32'h0, 128'h0,
                   1'b1, 32'h3FF0};
        vt[9]  = '{1'b0, 32'h3FF0, 32'h0, 0, 0, 1'b0, 32'h1234_5678, 1, 1'b0, 32'h0, 128'h0,
                   1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h3FF4, 32'h0, 0, 0, 1'b0, 32'h1111_3FF0, 1, 1'b0, 32'h0, 128'h0,
                   1'b0, 32'h0};
        vt[11] = '{1'b0, 32'h0,    32'h0, 0, 0, 1'b0, 32'h0, 4, 1'b0, 32'h0, 128'h0, 1'b1, 32'h0};
        vt[12] = '{1'b0, 32'h7FF8, 32'h0, 0, 0, 1'b0, 32'h2222_7FF0, 5, 1'b1, 32'h3FF0,
                   128'h3333_3FF0_2222_3FF0_1111_3FF0_1234_5678, 1'b1, 32'h7FF0};

        mem[32'h10] = 128'hDDDD_DDDD_0000_0004_0000_0003_0000_0002;
        model_reset();

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", cpu_req_ready, 1'b1);
        chk("rst_res_valid", cpu_res_valid, 1'b0);
        chk("rst_res_data", cpu_res_data, 32'h0);
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_req_addr, 32'h0);
        chk("rst_mem_data", mem_req_data, 128'h0);
        chk("rst_data_we", data_req_we, 1'b0);
        chk("rst_data_index", data_req_index, 10'h0);
        chk("rst_data_write", data_write, 128'h0);
        chk("rst_stats", {stat_hit, stat_miss, stat_wb}, 96'h0);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 13; i++) begin
            model_step(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].d, vt[i].r,
                       e_rd, e_lat, e_wb, e_wba, e_wbd, e_f, e_fa);
            run_req(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].d, vt[i].r, vt[i].poke,
                    a_rd, a_lat, a_nwb, a_wba, a_wbd, a_nf, a_fa);
            nm = $sformatf("vec%0d", i);
            if (!vt[i].rw) chk({nm, "_rdata"}, a_rd, vt[i].rdata);
            chk({nm, "_lat"}, a_lat, vt[i].lat);
            chk({nm, "_wb_cnt"}, a_nwb, vt[i].wb);
            if (vt[i].wb) begin
                chk({nm, "_wb_addr"}, a_wba, vt[i].wb_addr);
                chk({nm, "_wb_data"}, a_wbd, vt[i].wb_data);
            end
            chk({nm, "_fetch_cnt"}, a_nf, vt[i].fetch);
            if (vt[i].fetch) chk({nm, "_fetch_addr"}, a_fa, vt[i].f_addr);
            chk_stats(nm);
        end
`ifdef CACHE_STATS_EN
        chk("tbl_stat_hit", stat_hit, 32'd7);
        chk("tbl_stat_miss", stat_miss, 32'd6);
        chk("tbl_stat_wb", stat_wb, 32'd2);
`endif

        // Reset while waiting for a refill.
        @(negedge clk);
        chk("mr_ready", cpu_req_ready, 1'b1);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 32'h8020;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("mr_alloc_valid", mem_req_valid, 1'b1);
        chk("mr_alloc_rw", mem_req_rw, 1'b0);
        chk("mr_alloc_addr", mem_req_addr, 32'h8020);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("mr_wait_valid", mem_req_valid, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_req_ready", cpu_req_ready, 1'b1);
        chk("mr_mem_valid", mem_req_valid, 1'b0);
        chk("mr_res_valid", cpu_res_valid, 1'b0);
        chk("mr_data_we", data_req_we, 1'b0);
        chk("mr_stats", {stat_hit, stat_miss, stat_wb}, 96'h0);
        model_reset();
        run_checked(1'b0, 32'h1C, 32'h0, 0, 0, 1'b0, "post_rst_1c");
        run_checked(1'b0, 32'h3FF0, 32'h0, 1, 0, 1'b0, "post_rst_3ff0");
        run_checked(1'b0, 32'h8020, 32'h0, 0, 1, 1'b0, "post_rst_8020");

        // Random traffic over a few conflicting tags and the boundary indices.
        junk_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [17:0] tg;
            logic [9:0]  ix;
            logic [31:0] ad;
            tg = 18'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ix = 10'd0;
                1:       ix = 10'd1;
                2:       ix = 10'd2;
                3:       ix = 10'd1023;
                default: ix = 10'($urandom);
            endcase
            ad = {tg, ix, 2'($urandom), 2'b00};
            run_checked(1'($urandom_range(0, 1)), ad, $urandom, $urandom_range(0, 3),
                        $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                        $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
